spi_rx_deser: RTL and testbench

System-clock-domain SPI receiver that sits directly downstream of the SPI master FSM on the mosi/cs/sclk lines.
- Synchronizes and edge-detects sclk, cs_n and mosi, shifts bits in MSB first and presents each completed byte on a valid/ready interface to the consuming logic.
- Reports frame completion, partial-frame (framing) errors and receive overruns.
- Replaces the sclk-clocked slave with a fully synchronous, single-clock receiver.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_rx_deser.sv | 154 +++++++++++++++
 tb/tb_spi_rx_deser.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared types for the SPI receive path.
// Receiver FSM states and sclk sampling-edge selectors.
package spi_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    ACTIVE
  } rx_state_t;

  localparam int SAMPLE_FALL = 0;
  localparam int SAMPLE_RISE = 1;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer for one async input,
// plus a delay flop giving rise/fall strobes in the clk domain.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              dly;

  // Sync chain and one-cycle delay for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
      dly   <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      dly   <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~dly;
  assign fall = ~sync & dly;

endmodule

// File: rtl/spi_rx_deser.sv
// spi_rx_deser: single-clock SPI receiver, MSB-first words
// on valid/ready, with frame, framing-error and overrun status.
module spi_rx_deser
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int SAMPLE_EDGE = 0,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frame_words,
  output logic              frame_err,
  output logic              overrun,
  input  logic              clr_status
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [4:0] FLUSH_N = 5'(SYNC_STAGES + 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_n_s, cs_rise, cs_fall;
  logic samp_edge;
  logic mosi_s;
  logic [SYNC_STAGES-1:0] mosi_sync;

  rx_state_t         state;
  logic [4:0]        flush;
  logic [DATA_W-2:0] shreg;
  logic [BIT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  word_cnt;
  logic              dlv;
  logic [DATA_W-1:0] dlv_data;

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sclk (
    .clk (clk),
    .rst (rst),
    .d   (sclk),
    .sync(sclk_s),
    .rise(sclk_rise),
    .fall(sclk_fall)
  );

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_cs (
    .clk (clk),
    .rst (rst),
    .d   (cs_n),
    .sync(cs_n_s),
    .rise(cs_rise),
    .fall(cs_fall)
  );

  // mosi gets the same depth so it lines up with sclk_s
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mosi_sync <= '0;
    else     mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
  end

  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign samp_edge = (SAMPLE_EDGE == SAMPLE_RISE)
                   ? (sclk_rise & sclk_s)
                   : (sclk_fall & ~sclk_s);

  // Frame FSM: shift bits, count words, flag frame end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_IDLE;
      flush       <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      dlv         <= 1'b0;
      dlv_data    <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_words <= '0;
    end else begin
      dlv        <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state)
        WAIT_IDLE: begin
          // let reset values drain out of the sync chain first
          if (flush != FLUSH_N) flush <= flush + 5'd1;
          else if (cs_n_s)      state <= IDLE;
        end
        IDLE: begin
          if (cs_fall) begin
            state    <= ACTIVE;
            bit_cnt  <= '0;
            word_cnt <= '0;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state       <= IDLE;
            frame_done  <= 1'b1;
            frame_words <= word_cnt;
            frame_err   <= (bit_cnt != '0);
            bit_cnt     <= '0;
          end else if (samp_edge && !cs_n_s) begin
            shreg <= {shreg[DATA_W-3:0], mosi_s};
            if (bit_cnt == BIT_LAST) begin
              bit_cnt  <= '0;
              dlv      <= 1'b1;
              dlv_data <= {shreg, mosi_s};
              if (word_cnt != '1) word_cnt <= word_cnt + 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

  // Output holding register with valid/ready and overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (dlv && !(rx_valid && !rx_ready)) begin
        rx_data  <= dlv_data;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (clr_status)
        overrun <= 1'b0;
      else if (dlv && rx_valid && !rx_ready)
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_rx_deser.sv
// tb_spi_rx_deser: table-driven frames with a word scoreboard,
// plus overrun, async-reset and rising-edge sampling sequences.
module tb_spi_rx_deser;

  logic       clk, rst, sclk, cs_n, mosi, rx_ready, clr_status;
  logic [7:0] rx_data, rx_data1;
  logic       rx_valid, rx_valid1;
  logic       frame_done, frame_err, overrun;
  logic       frame_done1, frame_err1, overrun1;
  logic [7:0] frame_words, frame_words1;
  logic       rx_ready1;

  spi_rx_deser #(
    .DATA_W(8), .SYNC_STAGES(2), .SAMPLE_EDGE(0), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_done(frame_done), .frame_words(frame_words),
    .frame_err(frame_err), .overrun(overrun),
    .clr_status(clr_status)
  );

  spi_rx_deser #(
    .DATA_W(8), .SYNC_STAGES(2), .SAMPLE_EDGE(1), .CNT_W(8)
  ) dut1 (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
    .frame_done(frame_done1), .frame_words(frame_words1),
    .frame_err(frame_err1), .overrun(overrun1),
    .clr_status(clr_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int vcnt = 0, vcnt1 = 0, fd_cnt = 0, stray = 0, fd1_cnt = 0;
  logic [7:0] last_fw;
  logic       last_ferr;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: scoreboard pops on handshake, frame event capture
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid)  vcnt++;
      if (rx_valid1) vcnt1++;
      if (frame_done1) fd1_cnt++;
      if (rx_valid && rx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL word_unexpected: got %0h expected none",
                   rx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (rx_data !== e) begin
            errors++;
            $display("FAIL word_data: got %0h expected %0h",
                     rx_data, e);
          end
        end
      end
      if (frame_done) begin
        fd_cnt++;
        last_fw   = frame_words;
        last_ferr = frame_err;
      end
      if (frame_err && !frame_done) stray++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    mosi = b;
    cyc(2);
    sclk = 1'b1;
    cyc(4);
    sclk = 1'b0;
    cyc(2);
  endtask

  task automatic send_frame(input int nbits, input logic [15:0] data);
    cs_n = 1'b0;
    cyc(8);
    for (int i = 0; i < nbits; i++) send_bit(data[nbits-1-i]);
    cyc(8);
    cs_n = 1'b1;
    cyc(16);
  endtask

  typedef struct {
    int          nbits;
    logic [15:0] data;
    int          words;
    logic        err;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int fd0, v0, v10, f10;
    tbl[0] = '{8,  16'h00AA, 1, 1'b0};
    tbl[1] = '{16, 16'h3CC3, 2, 1'b0};
    tbl[2] = '{5,  16'h0015, 0, 1'b1};
    tbl[3] = '{0,  16'h0000, 0, 1'b0};
    tbl[4] = '{13, 16'h14AB, 1, 1'b1};

    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    rx_ready = 1'b1; rx_ready1 = 1'b1; clr_status = 1'b0;
    cyc(3);
    chk("reset_outputs",
        {rx_data, rx_valid, frame_done, frame_words, frame_err, overrun},
        '0);
    rst = 1'b0;
    cyc(10);

    for (int t = 0; t < 5; t++) begin
      fd0 = fd_cnt;
      v0  = vcnt;
      for (int k = 0; k < tbl[t].words; k++)
        exp_q.push_back(8'(tbl[t].data >> (tbl[t].nbits - 8 * (k + 1))));
      send_frame(tbl[t].nbits, tbl[t].data);
      chk("frame_done_count", fd_cnt - fd0, 1);
      chk("frame_words", {24'd0, last_fw}, tbl[t].words);
      chk("frame_err", {31'd0, last_ferr}, {31'd0, tbl[t].err});
      chk("valid_cycles", vcnt - v0, tbl[t].words);
      chk("queue_drained", exp_q.size(), 0);
      chk("no_overrun", {31'd0, overrun}, 0);
    end
    chk("stray_frame_err", stray, 0);

    rx_ready = 1'b0;
    send_frame(16, 16'h3CC3);
    chk("ovr_valid_held", {31'd0, rx_valid}, 1);
    chk("ovr_data_kept", {24'd0, rx_data}, 32'h3C);
    chk("ovr_set", {31'd0, overrun}, 1);
    chk("ovr_frame_words", {24'd0, frame_words}, 2);
    cyc(10);
    chk("ovr_sticky", {31'd0, overrun}, 1);
    clr_status = 1'b1;
    cyc(1);
    clr_status = 1'b0;
    chk("ovr_cleared", {31'd0, overrun}, 0);
    chk("ovr_valid_after_clr", {31'd0, rx_valid}, 1);
    exp_q.push_back(8'h3C);
    rx_ready = 1'b1;
    cyc(3);
    chk("ovr_queue_drained", exp_q.size(), 0);
    chk("ovr_valid_dropped", {31'd0, rx_valid}, 0);

    cs_n = 1'b0;
    cyc(8);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs",
        {rx_data, rx_valid, frame_done, frame_words, frame_err, overrun},
        '0);
    cyc(2);
    rst = 1'b0;
    fd0 = fd_cnt;
    v0  = vcnt;
    cyc(2);
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    cyc(8);
    chk("post_reset_no_valid", vcnt - v0, 0);
    chk("post_reset_no_frame", fd_cnt - fd0, 0);
    cs_n = 1'b1;
    cyc(16);
    chk("wait_idle_no_frame", fd_cnt - fd0, 0);
    exp_q.push_back(8'h81);
    send_frame(8, 16'h0081);
    chk("after_reset_data", {24'd0, rx_data}, 32'h81);
    chk("after_reset_frame", fd_cnt - fd0, 1);
    chk("after_reset_queue", exp_q.size(), 0);

    v10 = vcnt1;
    f10 = fd1_cnt;
    exp_q.push_back(8'h5A);
    send_frame(8, 16'h005A);
    chk("rise_data", {24'd0, rx_data1}, 32'h5A);
    chk("rise_valid_cycles", vcnt1 - v10, 1);
    chk("rise_frame_words", {24'd0, frame_words1}, 1);
    chk("rise_frame_done", fd1_cnt - f10, 1);
    chk("rise_no_overrun", {30'd0, overrun1, frame_err1}, 0);
    chk("fall_data_5a", {24'd0, rx_data}, 32'h5A);
    chk("final_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
